// File: rtl/addr_reg_pkg.sv
// addr_reg_pkg: shared mode codes, FSM state encoding and default width for addr_reg_bank.
// Rev 1.0
`default_nettype none

package addr_reg_pkg;

   localparam int ADDR_W_DEF = 16;

   localparam logic [2:0] MODE_PASS    = 3'd0;
   localparam logic [2:0] MODE_READ    = 3'd1;
   localparam logic [2:0] MODE_LOAD    = 3'd2;
   localparam logic [2:0] MODE_POSTINC = 3'd3;
   localparam logic [2:0] MODE_PREDEC  = 3'd4;
   localparam logic [2:0] MODE_BURST   = 3'd5;

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_BURST = 1'b1
   } state_t;

endpackage

`default_nettype wire

// File: rtl/addr_burst_ctrl.sv
// addr_burst_ctrl: burst FSM with beat counter, latched pointer index and busy/done generation.
// Rev 1.0
`default_nettype none

module addr_burst_ctrl
   import addr_reg_pkg::*;
#(
   parameter int IDX_W = 2,
   parameter int LEN_W = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [IDX_W-1:0] start_idx,
   input  logic [LEN_W-1:0] start_len,
   output logic             op_ready,
   output logic             busy,
   output logic             done,
   output logic [IDX_W-1:0] burst_idx
);

   state_t             state, state_nx;
   logic [LEN_W-1:0]   beats_left, beats_left_nx;
   logic [IDX_W-1:0]   idx_q, idx_nx;
   logic               done_q, done_nx;

   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= ST_IDLE;
         beats_left <= '0;
         idx_q      <= '0;
         done_q     <= 1'b0;
      end else begin
         state      <= state_nx;
         beats_left <= beats_left_nx;
         idx_q      <= idx_nx;
         done_q     <= done_nx;
      end
   end

   always_comb begin
      state_nx      = state;
      beats_left_nx = beats_left;
      idx_nx        = idx_q;
      done_nx       = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start) begin
               state_nx      = ST_BURST;
               beats_left_nx = start_len;
               idx_nx        = start_idx;
            end
         end
         ST_BURST: begin
            beats_left_nx = beats_left - LEN_W'(1);
            // Last beat: done lands in the first IDLE cycle after it.
            if (beats_left == LEN_W'(1)) begin
               state_nx = ST_IDLE;
               done_nx  = 1'b1;
            end
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   assign op_ready  = (state == ST_IDLE);
   assign busy      = (state == ST_BURST);
   assign done      = done_q;
   assign burst_idx = idx_q;

endmodule

`default_nettype wire

// File: rtl/addr_reg_bank.sv
// addr_reg_bank: indexed pointer-register bank driving the memory address port.
// Rev 1.0
`default_nettype none

module addr_reg_bank
   import addr_reg_pkg::*;
#(
   parameter  int ADDR_W   = ADDR_W_DEF,
   parameter  int NUM_REGS = 4,
   parameter  int STEP     = 1,
   parameter  int LEN_W    = 4,
   localparam int IDX_W    = $clog2(NUM_REGS)
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [ADDR_W-1:0] addr_in,
   input  logic [IDX_W-1:0]  reg_idx,
   input  logic [2:0]        mode,
   input  logic              op_valid,
   output logic              op_ready,
   input  logic [LEN_W-1:0]  burst_len,
   output logic [ADDR_W-1:0] addr_out,
   output logic              addr_valid,
   output logic              busy,
   output logic              done
);

   localparam logic [ADDR_W-1:0] STEP_V = ADDR_W'(STEP);

   logic [ADDR_W-1:0] regs [NUM_REGS];
   logic              accept;
   logic              burst_start;
   logic [IDX_W-1:0]  burst_idx;
   logic              wr_en;
   logic [IDX_W-1:0]  wr_idx;
   logic [ADDR_W-1:0] wr_data;

   assign accept      = op_valid && op_ready;
   assign burst_start = accept && (mode == MODE_BURST) && (burst_len != '0);

   addr_burst_ctrl #(
      .IDX_W (IDX_W),
      .LEN_W (LEN_W)
   ) u_burst_ctrl (
      .clock     (clock),
      .reset     (reset),
      .start     (burst_start),
      .start_idx (reg_idx),
      .start_len (burst_len),
      .op_ready  (op_ready),
      .busy      (busy),
      .done      (done),
      .burst_idx (burst_idx)
   );

   always_comb begin
      addr_out   = addr_in;
      addr_valid = 1'b0;
      wr_en      = 1'b0;
      wr_idx     = reg_idx;
      wr_data    = addr_in;
      if (busy) begin
         addr_out   = regs[burst_idx];
         addr_valid = 1'b1;
         wr_en      = 1'b1;
         wr_idx     = burst_idx;
         wr_data    = regs[burst_idx] + STEP_V;
      end else if (accept) begin
         case (mode)
            MODE_READ: begin
               addr_out   = regs[reg_idx];
               addr_valid = 1'b1;
            end
            MODE_LOAD: begin
               addr_valid = 1'b1;
               wr_en      = 1'b1;
            end
            MODE_POSTINC: begin
               addr_out   = regs[reg_idx];
               addr_valid = 1'b1;
               wr_en      = 1'b1;
               wr_data    = regs[reg_idx] + STEP_V;
            end
            MODE_PREDEC: begin
               addr_out   = regs[reg_idx] - STEP_V;
               addr_valid = 1'b1;
               wr_en      = 1'b1;
               wr_data    = regs[reg_idx] - STEP_V;
            end
            MODE_BURST: addr_valid = 1'b0;
            default:    addr_valid = 1'b1;
         endcase
      end
      // Hold the memory port quiet while reset is asserted.
      if (reset) begin
         addr_out   = '0;
         addr_valid = 1'b0;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      end else if (wr_en) begin
         regs[wr_idx] <= wr_data;
      end
   end

endmodule

`default_nettype wire
